// File: rtl/mux_scan_sequencer.sv
// Scans a 4:1 mux: steps the select through channels 0..3, dwells on each, samples the
// mux result, and offers the packed 4-bit frame on a valid/ready port with sticky overrun.
module mux_scan_sequencer #(
    parameter int DWELL_CYCLES = 4,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       start,
    input  logic       cont,
    input  logic       mux_in,
    output logic [1:0] sel_out,
    output logic [3:0] frame_out,
    output logic       frame_valid,
    input  logic       frame_ready,
    output logic       busy,
    output logic       overrun
);

    typedef enum logic {
        S_IDLE,
        S_SCAN
    } state_t;

    localparam logic [CNT_W-1:0] RELOAD = CNT_W'(DWELL_CYCLES - 1);

    state_t           r_state;
    logic [1:0]       r_sel;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_shift;
    logic [3:0]       r_frame;
    logic             r_valid;
    logic             r_overrun;

    state_t           w_nextState;
    logic [1:0]       w_nextSel;
    logic [CNT_W-1:0] w_nextCnt;
    logic [3:0]       w_nextShift;
    logic [3:0]       w_nextFrame;
    logic             w_nextValid;
    logic             w_nextOverrun;
    logic [3:0]       w_newFrame;
    logic             w_sampleEdge;
    logic             w_complete;
    logic             w_accept;

    assign w_sampleEdge = (r_state == S_SCAN) && (r_cnt == '0);
    assign w_complete   = w_sampleEdge && (r_sel == 2'd3);
    assign w_accept     = r_valid && frame_ready;

    always_comb begin
        w_nextState   = r_state;
        w_nextSel     = r_sel;
        w_nextCnt     = r_cnt;
        w_nextShift   = r_shift;
        w_nextFrame   = r_frame;
        w_nextValid   = r_valid;
        w_nextOverrun = r_overrun;
        w_newFrame    = r_shift;
        w_newFrame[r_sel] = mux_in;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_nextState   = S_SCAN;
                    w_nextSel     = 2'd0;
                    w_nextCnt     = RELOAD;
                    w_nextOverrun = 1'b0;
                end
            end
            S_SCAN: begin
                if (!w_sampleEdge) begin
                    w_nextCnt = r_cnt - CNT_W'(1);
                end else begin
                    w_nextShift = w_newFrame;
                    if (r_sel != 2'd3) begin
                        w_nextSel = r_sel + 2'd1;
                        w_nextCnt = RELOAD;
                    end else begin
                        w_nextSel = 2'd0;
                        if (cont) begin
                            w_nextCnt = RELOAD;
                        end else begin
                            w_nextState = S_IDLE;
                        end
                    end
                end
            end
            default: w_nextState = S_IDLE;
        endcase

        // A completing frame may replace the held one only if it is being consumed this edge.
        if (w_complete) begin
            if (!r_valid || w_accept) begin
                w_nextFrame = w_newFrame;
                w_nextValid = 1'b1;
            end else begin
                w_nextOverrun = 1'b1;
            end
        end else if (w_accept) begin
            w_nextValid = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sel     <= 2'd0;
            r_cnt     <= '0;
            r_shift   <= 4'd0;
            r_frame   <= 4'd0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else if (ena) begin
            r_state   <= w_nextState;
            r_sel     <= w_nextSel;
            r_cnt     <= w_nextCnt;
            r_shift   <= w_nextShift;
            r_frame   <= w_nextFrame;
            r_valid   <= w_nextValid;
            r_overrun <= w_nextOverrun;
        end
    end

    assign sel_out     = r_sel;
    assign frame_out   = r_frame;
    assign frame_valid = r_valid;
    assign busy        = (r_state == S_SCAN);
    assign overrun     = r_overrun;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// Bench for mux_scan_sequencer: a DWELL=4 and a DWELL=1 instance share stimulus and are
// both compared each cycle against a phase-counting reference model.
module tb_mux_scan_sequencer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       ena = 1'b1;
    logic       start = 1'b0;
    logic       cont = 1'b0;
    logic       frameReady = 1'b0;
    logic       muxDrive = 1'b0;
    logic       emulate = 1'b0;
    logic [3:0] chanVals = 4'd0;

    logic [1:0] sel0, sel1;
    logic [3:0] frame0, frame1;
    logic       valid0, valid1, busy0, busy1, ovr0, ovr1;
    logic       muxIn0, muxIn1;

    int errors = 0;
    int checks = 0;

    // The downstream mux is emulated from each instance's own select when emulate is set.
    assign muxIn0 = emulate ? chanVals[sel0] : muxDrive;
    assign muxIn1 = emulate ? chanVals[sel1] : muxDrive;

    always #5 clk = ~clk;

    mux_scan_sequencer #(.DWELL_CYCLES(4), .CNT_W(8)) dut0 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cont(cont), .mux_in(muxIn0),
        .sel_out(sel0), .frame_out(frame0), .frame_valid(valid0), .frame_ready(frameReady),
        .busy(busy0), .overrun(ovr0)
    );

    mux_scan_sequencer #(.DWELL_CYCLES(1), .CNT_W(8)) dut1 (
        .clk(clk), .rst_n(rst_n), .ena(ena), .start(start), .cont(cont), .mux_in(muxIn1),
        .sel_out(sel1), .frame_out(frame1), .frame_valid(valid1), .frame_ready(frameReady),
        .busy(busy1), .overrun(ovr1)
    );

    bit       mScan[2]    = '{0, 0};
    int       mPhase[2]   = '{0, 0};
    logic [3:0] mShift[2] = '{4'd0, 4'd0};
    logic [3:0] mFrame[2] = '{4'd0, 4'd0};
    bit       mValid[2]   = '{0, 0};
    bit       mOverrun[2] = '{0, 0};
    int       md;
    bit       mAcc, mCmp;
    logic     mMx;

    function automatic int dwellOf(input int i);
        return (i == 0) ? 4 : 1;
    endfunction

    // Model counts elapsed cycles within a frame; the channel is phase/dwell.
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                mScan[i] = 0; mPhase[i] = 0; mShift[i] = 4'd0;
                mFrame[i] = 4'd0; mValid[i] = 0; mOverrun[i] = 0;
            end else if (ena) begin
                md = dwellOf(i);
                mMx = (i == 0) ? muxIn0 : muxIn1;
                mAcc = mValid[i] && frameReady;
                mCmp = 0;
                if (!mScan[i]) begin
                    if (start) begin
                        mScan[i] = 1; mPhase[i] = 0; mOverrun[i] = 0;
                    end
                end else begin
                    if (mPhase[i] % md == md - 1) mShift[i][mPhase[i] / md] = mMx;
                    if (mPhase[i] == 4 * md - 1) begin
                        mCmp = 1; mPhase[i] = 0;
                        if (!cont) mScan[i] = 0;
                    end else begin
                        mPhase[i]++;
                    end
                end
                if (mCmp) begin
                    if (!mValid[i] || mAcc) begin
                        mFrame[i] = mShift[i]; mValid[i] = 1;
                    end else begin
                        mOverrun[i] = 1;
                    end
                end else if (mAcc) begin
                    mValid[i] = 0;
                end
            end
        end
    end

    function automatic logic [8:0] expVec(input int i);
        logic [1:0] s;
        s = mScan[i] ? 2'(mPhase[i] / dwellOf(i)) : 2'd0;
        return {s, mFrame[i], mValid[i], mScan[i], mOverrun[i]};
    endfunction

    function automatic logic [8:0] gotVec(input int i);
        return (i == 0) ? {sel0, frame0, valid0, busy0, ovr0} : {sel1, frame1, valid1, busy1, ovr1};
    endfunction

    task automatic applyReset();
        @(negedge clk);
        rst_n = 1'b0; ena = 1'b1; start = 1'b0; cont = 1'b0;
        frameReady = 1'b0; muxDrive = 1'b0; emulate = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic pulseStart();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic test_reset();
        #3 rst_n = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (gotVec(i) !== 9'd0) begin
                errors++; $display("[TB] FAIL reset_state inst=%0d got=%b exp=%b", i, gotVec(i), 9'd0);
            end
        end
        rst_n = 1'b1;
    endtask

    task automatic test_single_shot();
        logic [1:0] expSel;
        applyReset();
        emulate = 1'b1; chanVals = 4'b1101;
        pulseStart();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (gotVec(i) !== expVec(i)) begin
                    errors++; $display("[TB] FAIL single_model inst=%0d edge=%0d got=%b exp=%b", i, k, gotVec(i), expVec(i));
                end
            end
            expSel = (k < 16) ? 2'(k / 4) : 2'd0;
            checks++;
            if (sel0 !== expSel) begin
                errors++; $display("[TB] FAIL single_sel edge=%0d got=%0d exp=%0d", k, sel0, expSel);
            end
            if (k == 15) begin
                checks++;
                if ({valid0, busy0} !== 2'b01) begin
                    errors++; $display("[TB] FAIL single_pre edge=15 got valid/busy=%b exp=01", {valid0, busy0});
                end
            end
            if (k == 16) begin
                checks++;
                if ({frame0, valid0, busy0} !== 6'b1101_1_0) begin
                    errors++; $display("[TB] FAIL single_done got=%b exp=%b", {frame0, valid0, busy0}, 6'b1101_1_0);
                end
            end
        end
    endtask

    task automatic test_overrun();
        applyReset();
        emulate = 1'b1; chanVals = 4'b1101; cont = 1'b1;
        pulseStart();
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (gotVec(i) !== expVec(i)) begin
                    errors++; $display("[TB] FAIL overrun_model inst=%0d edge=%0d got=%b exp=%b", i, k, gotVec(i), expVec(i));
                end
            end
            if (k == 16) begin
                checks++;
                if (ovr0 !== 1'b0) begin
                    errors++; $display("[TB] FAIL overrun_early got=%b exp=0", ovr0);
                end
            end
        end
        checks++;
        if ({ovr0, frame0, valid0} !== 6'b1_1101_1) begin
            errors++; $display("[TB] FAIL overrun_set got=%b exp=%b", {ovr0, frame0, valid0}, 6'b1_1101_1);
        end
    endtask

    task automatic test_back_to_back();
        applyReset();
        emulate = 1'b1; chanVals = 4'b1101; cont = 1'b1;
        pulseStart();
        for (int k = 1; k <= 32; k++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (gotVec(i) !== expVec(i)) begin
                    errors++; $display("[TB] FAIL b2b_model inst=%0d edge=%0d got=%b exp=%b", i, k, gotVec(i), expVec(i));
                end
            end
            if (k == 16) chanVals = 4'b0110;
            frameReady = (k == 31);
        end
        checks++;
        if ({ovr0, frame0, valid0} !== 6'b0_0110_1) begin
            errors++; $display("[TB] FAIL b2b_load got=%b exp=%b", {ovr0, frame0, valid0}, 6'b0_0110_1);
        end
    endtask

    task automatic test_reset_midscan();
        applyReset();
        emulate = 1'b1; chanVals = 4'b1101;
        pulseStart();
        repeat (7) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (gotVec(i) !== 9'd0) begin
                errors++; $display("[TB] FAIL midscan_reset inst=%0d got=%b exp=%b", i, gotVec(i), 9'd0);
            end
        end
        @(negedge clk); rst_n = 1'b1; chanVals = 4'b0010;
        pulseStart();
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            checks++;
            if (gotVec(0) !== expVec(0)) begin
                errors++; $display("[TB] FAIL restart_model edge=%0d got=%b exp=%b", k, gotVec(0), expVec(0));
            end
        end
        checks++;
        if ({frame0, valid0} !== 5'b0010_1) begin
            errors++; $display("[TB] FAIL restart_frame got=%b exp=%b", {frame0, valid0}, 5'b0010_1);
        end
    endtask

    task automatic test_ena_freeze();
        applyReset();
        emulate = 1'b1; chanVals = 4'b1101;
        pulseStart();
        for (int k = 1; k <= 21; k++) begin
            @(negedge clk);
            checks++;
            if (gotVec(0) !== expVec(0)) begin
                errors++; $display("[TB] FAIL freeze_model edge=%0d got=%b exp=%b", k, gotVec(0), expVec(0));
            end
            if (k >= 7 && k <= 11) begin
                checks++;
                if ({sel0, busy0} !== 3'b01_1) begin
                    errors++; $display("[TB] FAIL freeze_sel edge=%0d got=%b exp=011", k, {sel0, busy0});
                end
            end
            if (k == 20 || k == 21) begin
                checks++;
                if (valid0 !== (k == 21)) begin
                    errors++; $display("[TB] FAIL freeze_valid edge=%0d got=%b exp=%b", k, valid0, (k == 21));
                end
            end
            ena = !(k >= 6 && k <= 10);
        end
    endtask

    task automatic test_dwell_one();
        applyReset();
        cont = 1'b1; frameReady = 1'b1;
        @(negedge clk); start = 1'b1; muxDrive = ~muxDrive;
        @(negedge clk); start = 1'b0; muxDrive = ~muxDrive;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            checks++;
            if (gotVec(1) !== expVec(1)) begin
                errors++; $display("[TB] FAIL d1_model edge=%0d got=%b exp=%b", k, gotVec(1), expVec(1));
            end
            if (k % 4 == 0) begin
                checks++;
                if (!(valid1 === 1'b1 && (frame1 === 4'b1010 || frame1 === 4'b0101))) begin
                    errors++; $display("[TB] FAIL d1_frame edge=%0d got valid=%b frame=%b exp valid=1 frame=1010/0101", k, valid1, frame1);
                end
            end
            muxDrive = ~muxDrive;
        end
        checks++;
        if (ovr1 !== 1'b0) begin
            errors++; $display("[TB] FAIL d1_overrun got=%b exp=0", ovr1);
        end
    endtask

    task automatic test_random();
        applyReset();
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                checks++;
                if (gotVec(i) !== expVec(i)) begin
                    errors++; $display("[TB] FAIL random_model inst=%0d cycle=%0d got=%b exp=%b", i, c, gotVec(i), expVec(i));
                end
            end
            rst_n = 1'b1;
            start = ($urandom_range(0, 3) == 0);
            cont = $urandom_range(0, 1);
            frameReady = $urandom_range(0, 1);
            ena = ($urandom_range(0, 4) != 0);
            muxDrive = $urandom_range(0, 1);
            if ($urandom_range(0, 199) == 0) #2 rst_n = 1'b0;
        end
    endtask

    initial begin
        $display("[TB] starting mux_scan_sequencer bench");
        test_reset();
        test_single_shot();
        test_overrun();
        test_back_to_back();
        test_reset_midscan();
        test_ena_freeze();
        test_dwell_one();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
